// File: rtl/prio_scan_enc.sv
// prio_scan_enc: sequential priority encoder.
// Accepts a WIDTH-bit request vector through a valid/ready handshake. It then
// emits the index of every set bit, one bit per beat, highest index first.
// The final beat of each vector carries out_last. An all-zero vector produces
// a single beat with out_zero=1.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/req_ready/req  request vector handshake
//   out_valid/out_ready      output beat handshake
//   out_code                 index of the bit reported by the current beat
//   out_last                 current beat is the last one for this vector
//   out_zero                 accepted vector was all zeros
//   busy                     a vector is being walked
//   dir                      (only with PRIO_SCAN_DIR_EN) 1 = scan lowest bit first
//
// Optional feature macro: PRIO_SCAN_DIR_EN adds the dir input.
module prio_scan_enc #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req,
`ifdef PRIO_SCAN_DIR_EN
  input  logic             dir,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_code,
  output logic             out_last,
  output logic             out_zero,
  output logic             busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;
`ifdef PRIO_SCAN_DIR_EN
  logic             dir_q, dir_d;
`endif

  logic [IDXW-1:0]  hi_idx, lo_idx, sel_idx;
  logic             one_left;
  logic             emit;

  // Scan the pending bits from the registered state only. The ascending loop
  // keeps the highest set bit. The descending loop keeps the lowest set bit.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (pending_q[i]) hi_idx = IDXW'(i);
    for (int i = WIDTH - 1; i >= 0; i--)
      if (pending_q[i]) lo_idx = IDXW'(i);
  end

`ifdef PRIO_SCAN_DIR_EN
  assign sel_idx = dir_q ? lo_idx : hi_idx;
`else
  assign sel_idx = hi_idx;
`endif

  // Exactly one bit set: non-zero, and clearing the lowest set bit gives zero.
  assign one_left = (pending_q != '0) &&
                    ((pending_q & (pending_q - WIDTH'(1))) == '0);

  assign emit      = (state_q == EMIT);
  assign busy      = emit;
  assign req_ready = !emit;
  assign out_valid = emit;
  assign out_zero  = emit && zero_q;
  assign out_last  = emit && (zero_q || one_left);
  assign out_code  = (emit && !zero_q) ? sel_idx : '0;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
`ifdef PRIO_SCAN_DIR_EN
    dir_d     = dir_q;
`endif
    if (!emit) begin
      if (req_valid) begin
        pending_d = req;
        zero_d    = (req == '0);
        state_d   = EMIT;
`ifdef PRIO_SCAN_DIR_EN
        dir_d     = dir;
`endif
      end
    end else if (out_ready) begin
      if (zero_q) begin
        state_d = IDLE;
      end else begin
        // Clear the bit that was just reported. A shift-built mask keeps the
        // index inside the vector even when WIDTH is not a power of two.
        pending_d = pending_q & ~(WIDTH'(1) << sel_idx);
        if (one_left) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
`ifdef PRIO_SCAN_DIR_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
`ifdef PRIO_SCAN_DIR_EN
      dir_q     <= dir_d;
`endif
    end
  end

endmodule

// File: doc/prio_scan_enc.md
# prio_scan_enc

Parametrised sequential priority encoder for the LED cube datapath. It accepts a WIDTH-bit request vector through a valid/ready handshake and latches it. It then emits the index of every set bit, one per output beat, highest index first, with an end-of-vector marker. It succeeds the 8-bit combinational encoder wherever a layer/column refresh vector must be walked bit by bit rather than reduced to its top bit.

## Interface
- WIDTH, 8, request vector width; legal range 2..64
- IDXW, $clog2(WIDTH), width of the emitted index; derived, never overridden
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request vector present
- req_ready  out  1  block can accept a vector
- req  in  WIDTH  request vector, sampled on accept
- out_valid  out  1  out_code/out_last/out_zero valid
- out_ready  in  1  consumer takes current beat
- out_code  out  IDXW  index of current highest pending bit
- out_last  out  1  current beat is final beat for this vector
- out_zero  out  1  accepted vector was all zeros (z of the old encoder)
- busy  out  1  high whenever state is not IDLE

## Operation
- State: 1-bit FSM {IDLE, EMIT}, WIDTH-bit pending register, 1-bit zero flag.
- IDLE: req_ready=1, out_valid=0. Accept when req_valid && req_ready: pending<=req, zero<=(req==0), state<=EMIT.
- EMIT: req_ready=0, out_valid=1.
  - zero=1: out_code=0, out_zero=1, out_last=1. On out_ready, state goes to IDLE.
  - zero=0: out_code=index of highest set bit of pending, out_zero=0, out_last=(pending has exactly one bit set). On out_ready, that bit is cleared in pending. If out_last, state goes to IDLE.
- out_valid is held and out_code is stable while out_ready=0, for any number of cycles.
- out_code, out_last and out_zero are decoded from registered state only. There is no combinational path from any input to any output.
- Index arithmetic: bit i is reported as i in IDXW bits. WIDTH that is not a power of two never yields an index >= WIDTH.
- req is ignored outside the accept cycle. req_valid in EMIT has no effect.
- Beats for one vector = popcount(req), or 1 if req==0.

## Timing
- Reset: state=IDLE, pending=0, zero=0. Outputs after reset: req_ready=1, out_valid=0, out_code=0, out_last=0, out_zero=0, busy=0.
- rst has priority over every other event, including an accept or a beat in the same cycle. Reset mid-vector drops all remaining bits, and out_valid is 0 in the cycle after the reset edge.
- Latency: vector accepted at edge N gives first beat valid in cycle N+1.
- Throughput: one beat per cycle while out_ready=1.
- Turnaround: the final beat completes at edge M. req_ready=1 in cycle M+1, and the next vector is accepted no earlier than edge M+1. This gives one idle cycle between vectors.
- busy equals (state==EMIT).

## Configuration
- PRIO_SCAN_DIR_EN defined: adds input port dir (1 bit), sampled with req on accept and held for the whole vector.
  - dir=0 scans highest-first.
  - dir=1 scans lowest-first: out_code is the lowest set bit, and that bit is the one cleared on each beat.
  - out_last and out_zero rules are unchanged.
- PRIO_SCAN_DIR_EN undefined: the dir port is absent and scanning is always highest-first.

## Test plan
- Reset then idle, WIDTH=8: rst=1 for 2 cycles -> req_ready=1, out_valid=0, busy=0, out_code=0.
- req=8'b1010_0110 with out_ready=1 -> out_code 7,5,2,1 on consecutive cycles, out_last=1 only on code 1, req_ready=1 in the following cycle.
- req=8'h00 -> one beat with out_code=0, out_zero=1, out_last=1, then IDLE. req=8'h01 -> one beat with out_code=0, out_zero=0, out_last=1.
- Backpressure: req=8'h81 with out_ready=0 for 5 cycles -> out_code=7 held stable with out_valid=1, no bit lost. Then code 0 with out_last.
- rst asserted during second beat of req=8'hFF -> out_valid=0 next cycle, req_ready=1. New req=8'h10 yields a single code 4.
- WIDTH=12, req=12'h801 with PRIO_SCAN_DIR_EN and dir=1 -> codes 0 then 11, out_last on 11. Same vector with dir=0 -> codes 11 then 0.
